// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - edge-triggered, priority-encoded interrupt controller with req/ack/complete handshake
//
// Purpose:
//   Turns rising edges on NUM_SRC level interrupt lines into pending bits.
//   Pending bits are masked by ENABLE, and the lowest-numbered active source
//   is presented to the core. One interrupt is in service at a time; the next
//   request is blocked until software writes the in-service id to CLAIM.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   data_i, addr_i   register write data / address (addr_i[3:0] decoded)
//   we_i             register write enable
//   data_o           combinational register read data (0 during reset)
//   int_src_i        interrupt source levels, bit 0 highest priority
//   int_req_o        interrupt request to core (registered)
//   int_id_o         id of requested source (registered)
//   int_ack_i        core acceptance pulse
//
// Register map (addr_i[3:0]):
//   0x0 ENABLE  RW   0x4 PENDING  R/W1C
//   0x8 CLAIM   R {busy, in_service_id}, W complete id
//   0xC STATUS  R state (IDLE=0, REQ=1, SERVE=2)

module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    input  logic [NUM_SRC-1:0] int_src_i,
    output logic               int_req_o,
    output logic [4:0]         int_id_o,
    input  logic               int_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic [4:0]         id_q, id_d;
    logic [4:0]         isid_q, isid_d;
    logic               busy_q, busy_d;
    logic               req_q, req_d;

    logic               wr_enable, wr_pending, wr_claim;
    logic [NUM_SRC-1:0] rise, active, clr, id_mask;
    logic [4:0]         sel;
    logic               cur_active;
    logic [31:0]        enable_ext, pending_ext, rdata;
    logic               unused_bits;

    // Upper address bits and unused data bits are intentionally ignored.
    assign unused_bits = ^{addr_i[31:4], data_i};

    assign wr_enable  = we_i && (addr_i[3:0] == 4'h0);
    assign wr_pending = we_i && (addr_i[3:0] == 4'h4);
    assign wr_claim   = we_i && (addr_i[3:0] == 4'h8);

    assign rise   = int_src_i & ~src_q;
    assign active = pending_q & enable_q;

    // Lowest-numbered active source wins; scan downward so the last hit is the lowest.
    always_comb begin
        sel = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = 5'(i);
            end
        end
    end

    // One-hot of the latched id, plus whether that source is still pending and enabled.
    always_comb begin
        id_mask    = '0;
        cur_active = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (5'(i) == id_q) begin
                id_mask[i] = 1'b1;
                cur_active = active[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        isid_d   = isid_q;
        busy_d   = busy_q;
        clr      = wr_pending ? data_i[NUM_SRC-1:0] : '0;

        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    state_d = ST_REQ;
                    id_d    = sel;
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a same-cycle withdraw.
                if (int_ack_i) begin
                    state_d = ST_SERVE;
                    clr     = clr | id_mask;
                    isid_d  = id_q;
                    busy_d  = 1'b1;
                end else if (!cur_active) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (wr_claim && (data_i[4:0] == isid_q)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new edge on the same cycle as a clear keeps the bit set.
        pending_d = (pending_q & ~clr) | rise;
        enable_d  = wr_enable ? data_i[NUM_SRC-1:0] : enable_q;
        src_d     = int_src_i;
        req_d     = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            enable_q  <= '0;
            pending_q <= '0;
            src_q     <= '0;
            id_q      <= 5'd0;
            isid_q    <= 5'd0;
            busy_q    <= 1'b0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            src_q     <= src_d;
            id_q      <= id_d;
            isid_q    <= isid_d;
            busy_q    <= busy_d;
            req_q     <= req_d;
        end
    end

    // Zero-extend the NUM_SRC-wide registers without a zero-width replication at NUM_SRC=32.
    always_comb begin
        enable_ext                = '0;
        enable_ext[NUM_SRC-1:0]   = enable_q;
        pending_ext               = '0;
        pending_ext[NUM_SRC-1:0]  = pending_q;
    end

    always_comb begin
        rdata = '0;
        case (addr_i[3:0])
            4'h0:    rdata = enable_ext;
            4'h4:    rdata = pending_ext;
            4'h8:    rdata = {busy_q, 26'd0, isid_q};
            4'hC:    rdata = {30'd0, state_q};
            default: rdata = '0;
        endcase
    end

    assign data_o    = rst ? 32'd0 : rdata;
    assign int_req_o = req_q;
    assign int_id_o  = id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - scoreboard bench for int_ctrl with directed scenarios and random traffic

module tb_int_ctrl;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   data_i = '0;
    logic [31:0]   addr_i = '0;
    logic          we_i = 1'b0;
    logic [31:0]   data_o;
    logic [N-1:0]  int_src_i = '0;
    logic          int_req_o;
    logic [4:0]    int_id_o;
    logic          int_ack_i = 1'b0;

    always #5 clk = ~clk;

    int_ctrl #(.NUM_SRC(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .data_o    (data_o),
        .int_src_i (int_src_i),
        .int_req_o (int_req_o),
        .int_id_o  (int_id_o),
        .int_ack_i (int_ack_i)
    );

    typedef struct packed {
        logic        req;
        logic [4:0]  id;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: state as named integers, registers as plain bit vectors.
    localparam int M_IDLE = 0, M_REQ = 1, M_SERVE = 2;
    bit [N-1:0] m_en, m_pend, m_src;
    int         m_state, m_id, m_isid;
    bit         m_busy;
    logic [N-1:0] cur_src = '0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[3:0])
            4'h0:    return 32'(m_en);
            4'h4:    return 32'(m_pend);
            4'h8:    return {m_busy, 26'd0, 5'(m_isid)};
            4'hC:    return 32'(m_state);
            default: return 32'd0;
        endcase
    endfunction

    // Applies the inputs held during the cycle that just ended to the model.
    task automatic model_step();
        bit [N-1:0] rise, clr, act;
        int pick;
        if (rst) begin
            m_en = '0; m_pend = '0; m_src = '0;
            m_state = M_IDLE; m_id = 0; m_isid = 0; m_busy = 0;
            return;
        end
        rise = int_src_i & ~m_src;
        clr  = (we_i && addr_i[3:0] == 4'h4) ? data_i[N-1:0] : '0;
        act  = m_pend & m_en;
        if (m_state == M_IDLE) begin
            if (act != 0) begin
                pick = N;
                for (int i = N - 1; i >= 0; i--) if (act[i]) pick = i;
                m_state = M_REQ;
                m_id    = pick;
            end
        end else if (m_state == M_REQ) begin
            if (int_ack_i) begin
                m_state    = M_SERVE;
                clr[m_id]  = 1'b1;
                m_isid     = m_id;
                m_busy     = 1'b1;
            end else if (!act[m_id]) begin
                m_state = M_IDLE;
            end
        end else if (we_i && addr_i[3:0] == 4'h8 && data_i[4:0] == 5'(m_isid)) begin
            m_state = M_IDLE;
            m_busy  = 1'b0;
        end
        m_pend = (m_pend & ~clr) | rise;
        if (we_i && addr_i[3:0] == 4'h0) m_en = data_i[N-1:0];
        m_src = int_src_i;
    endtask

    // k: 0 = no ack, 1 = ack, 2 = ack only if the model says a request is up.
    task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [N-1:0] s, input int k);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        rst       = r;
        we_i      = w;
        addr_i    = a;
        data_i    = d;
        int_src_i = s;
        int_ack_i = (k == 1) || (k == 2 && m_state == M_REQ);
        e.req = (m_state == M_REQ);
        e.id  = 5'(m_id);
        e.rd  = r ? 32'd0 : m_read(a);
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[3:0] = 4'($urandom_range(0, 3) * 4);
        return a;
    endfunction

    task automatic tick(input int k);
        cycle(1'b0, 1'b0, rand_addr(), $urandom, cur_src, k);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        logic [31:0] a;
        a = $urandom;
        a[3:0] = off;
        cycle(1'b0, 1'b1, a, d, cur_src, 0);
    endtask

    task automatic ticks(input int n, input int k);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (int_req_o !== e.req) begin
                n_bad++;
                $display("FAIL int_req_o t=%0t got %0b expected %0b", $time, int_req_o, e.req);
            end
            if (e.req) begin
                n_cmp++;
                if (int_id_o !== e.id) begin
                    n_bad++;
                    $display("FAIL int_id_o t=%0t got %0d expected %0d", $time, int_id_o, e.id);
                end
            end
            n_cmp++;
            if (data_o !== e.rd) begin
                n_bad++;
                $display("FAIL data_o t=%0t addr=%h got %h expected %h", $time, addr_i, data_o, e.rd);
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  off;

        // Reset.
        cycle(1'b1, 1'b0, 32'h0, 32'h0, '0, 0);
        cycle(1'b1, 1'b0, 32'h8, 32'h0, '0, 0);
        ticks(3, 0);

        // Single source 0.
        wr(4'h0, 32'h1);
        cur_src = 8'h01;
        ticks(4, 0);
        ticks(3, 2);
        cur_src = 8'h00;
        ticks(2, 0);
        wr(4'h8, 32'h0);
        ticks(3, 0);

        // Priority: sources 5 and 2 together.
        wr(4'h0, 32'hFF);
        cur_src = 8'h24;
        ticks(3, 0);
        ticks(2, 2);
        wr(4'h8, 32'h2);
        ticks(3, 2);
        wr(4'h8, 32'h5);
        cur_src = 8'h00;
        ticks(3, 0);

        // Withdraw by W1C while requesting.
        wr(4'h0, 32'h08);
        cur_src = 8'h08;
        ticks(3, 0);
        wr(4'h4, 32'h08);
        ticks(4, 0);
        cur_src = 8'h00;

        // Held level across complete, then drop and re-raise.
        wr(4'h0, 32'h01);
        cur_src = 8'h01;
        ticks(3, 2);
        wr(4'h8, 32'h0);
        ticks(5, 2);
        cur_src = 8'h00;
        tick(0);
        cur_src = 8'h01;
        ticks(4, 2);
        wr(4'h8, 32'h0);
        cur_src = 8'h00;

        // Collision: W1C of bit 1 alongside a fresh edge on source 1; wrong-id claim.
        wr(4'h0, 32'h02);
        cur_src = 8'h02;
        ticks(4, 2);
        cur_src = 8'h00;
        tick(0);
        cur_src = 8'h02;
        wr(4'h4, 32'h02);
        ticks(2, 0);
        wr(4'h8, 32'h4);
        ticks(2, 0);
        wr(4'h8, 32'h1);
        ticks(3, 0);

        // Reset while serving.
        ticks(3, 2);
        cycle(1'b1, 1'b0, 32'h8, 32'h0, cur_src, 1);
        cycle(1'b1, 1'b0, 32'h4, 32'h0, cur_src, 0);
        ticks(4, 0);
        cur_src = 8'h00;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) cur_src[b] = ~cur_src[b];
            if ($urandom_range(0, 199) == 0) begin
                cycle(1'b1, 1'b0, rand_addr(), $urandom, cur_src, 0);
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: begin off = 4'h0; d = $urandom; end
                    1: begin off = 4'h4; d = $urandom; end
                    2: begin off = 4'h8; d = ($urandom_range(0, 3) != 0) ? 32'(m_isid) : $urandom; end
                    3: begin off = 4'hC; d = $urandom; end
                    default: begin off = 4'($urandom_range(0, 15)); d = $urandom; end
                endcase
                wr(off, d);
            end else begin
                tick(($urandom_range(0, 19) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 2 : 0));
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
